// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter sharing one cache-side bus port among NUM_PORTS
// requesters. A grant is held for a whole transaction and released on the
// owner's done pulse, on the owner dropping its request, or when the optional
// MAX_HOLD limit expires. A turnaround cycle with no owner always separates
// two grants.
module cache_bus_arbiter #(
  parameter  int NUM_PORTS = 4,
  parameter  int MAX_HOLD  = 0,
  localparam int ID_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] request,
  input  logic [NUM_PORTS-1:0] done,
  output logic [NUM_PORTS-1:0] grant,
  output logic [ID_W-1:0]      grant_id,
  output logic                 grant_valid,
  output logic                 preempt
);

  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  // The counter value seen in the last allowed cycle, and its saturation value.
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD : 0);

  typedef enum logic {
    IDLE,
    OWN
  } state_t;

  state_t          state;
  logic [ID_W-1:0] ptr;
  logic [CNT_W-1:0] hold_cnt;

  logic [ID_W-1:0]      win_id;
  logic [NUM_PORTS-1:0] win_onehot;
  logic                 found;
  logic                 own_done;
  logic                 own_req;
  logic                 limit_hit;
  logic                 release_now;
  logic [ID_W-1:0]      next_ptr;

  // Pick the first requester at or after ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    win_id = '0;
    found  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int idx;
      idx = int'(ptr) + i;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!found && request[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
    win_onehot         = '0;
    win_onehot[win_id] = 1'b1;
  end

  // Release conditions for the current owner.
  always_comb begin
    own_done    = done[grant_id];
    own_req     = request[grant_id];
    limit_hit   = (MAX_HOLD > 0) && (hold_cnt == HOLD_LAST);
    release_now = own_done || !own_req || limit_hit;
    next_ptr    = (int'(grant_id) == NUM_PORTS - 1) ? '0 : grant_id + 1'b1;
  end

  // Arbitration FSM with registered grant outputs.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: the reset is asynchronous so a mid-transaction reset removes the
    // grant at once instead of waiting for the next clock edge.
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant       <= '0;
      grant_id    <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values present before the edge, independent of statement order.
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant       <= win_onehot;
            grant_id    <= win_id;
            grant_valid <= 1'b1;
            hold_cnt    <= '0;
            state       <= OWN;
          end
        end
        OWN: begin
          if (release_now) begin
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            ptr         <= next_ptr;
            hold_cnt    <= '0;
            preempt     <= limit_hit && !own_done && own_req;
            state       <= IDLE;
          end else if (hold_cnt < HOLD_SAT) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Directed testbench for cache_bus_arbiter. One instance runs with unlimited
// hold, a second with MAX_HOLD=4 for the preemption scenarios. Inputs change
// and outputs are sampled on the falling clock edge.
module tb_cache_bus_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] request = '0;
  logic [3:0] done = '0;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       preempt;

  logic [3:0] h_request = '0;
  logic [3:0] h_done = '0;
  logic [3:0] h_grant;
  logic [1:0] h_grant_id;
  logic       h_grant_valid;
  logic       h_preempt;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  cache_bus_arbiter #(.NUM_PORTS(4), .MAX_HOLD(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .request     (request),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  cache_bus_arbiter #(.NUM_PORTS(4), .MAX_HOLD(4)) dut_hold (
    .clock       (clock),
    .reset       (reset),
    .request     (h_request),
    .done        (h_done),
    .grant       (h_grant),
    .grant_id    (h_grant_id),
    .grant_valid (h_grant_valid),
    .preempt     (h_preempt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then park on the following falling edge.
  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic expect_main(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v);
    check({tag, ".grant"}, 32'(grant), 32'(g));
    check({tag, ".id"}, 32'(grant_id), 32'(id));
    check({tag, ".valid"}, 32'(grant_valid), 32'(v));
    check({tag, ".preempt"}, 32'(preempt), 32'd0);
  endtask

  task automatic expect_hold(input string tag, input logic [3:0] g, input logic [1:0] id,
                             input logic v, input logic p);
    check({tag, ".grant"}, 32'(h_grant), 32'(g));
    check({tag, ".id"}, 32'(h_grant_id), 32'(id));
    check({tag, ".valid"}, 32'(h_grant_valid), 32'(v));
    check({tag, ".preempt"}, 32'(h_preempt), 32'(p));
  endtask

  initial begin
    // Reset held for three cycles while everyone requests.
    request = 4'b1111;
    repeat (3) @(negedge clock);
    expect_main("reset", 4'b0000, 2'd0, 1'b0);
    expect_hold("reset_h", 4'b0000, 2'd0, 1'b0, 1'b0);

    // First grant one cycle after reset release, starting at ptr=0.
    reset = 1'b1;
    step();
    expect_main("first", 4'b0001, 2'd0, 1'b1);

    // Rotation 0,1,2,3,0 with a turnaround cycle between grants.
    for (int n = 1; n <= 4; n++) begin
      done = 4'b0001 << ((n - 1) % 4);
      step();
      expect_main($sformatf("turn%0d", n), 4'b0000, 2'd0, 1'b0);
      done = 4'b0000;
      step();
      expect_main($sformatf("rot%0d", n), 4'(4'b0001 << (n % 4)), 2'(n % 4), 1'b1);
    end
    // Owner 0 finishes: ptr becomes 1.
    request = 4'b0000;
    done    = 4'b0001;
    step();
    done = 4'b0000;
    step();
    expect_main("idle_empty", 4'b0000, 2'd0, 1'b0);

    // Single requester 2, done at the fourth owning edge; ptr becomes 3.
    request = 4'b0100;
    step();
    expect_main("single_e1", 4'b0100, 2'd2, 1'b1);
    done = 4'b0011;  // non-owner done bits must be ignored
    for (int k = 2; k <= 4; k++) begin
      step();
      expect_main($sformatf("single_e%0d", k), 4'b0100, 2'd2, 1'b1);
      done = 4'b0000;
    end
    done = 4'b0100;
    step();
    expect_main("single_rel", 4'b0000, 2'd0, 1'b0);
    done    = 4'b0000;
    request = 4'b0000;
    step();

    // Wrap and skip: ptr=3 with requests 0,1 -> 0 wins, then ptr=1 -> 1 wins.
    request = 4'b0011;
    step();
    expect_main("wrap", 4'b0001, 2'd0, 1'b1);
    done = 4'b0001;
    step();
    expect_main("wrap_turn", 4'b0000, 2'd0, 1'b0);
    done = 4'b0000;
    step();
    expect_main("skip", 4'b0010, 2'd1, 1'b1);
    // Release by dropping the request; ptr becomes 2.
    request = 4'b0000;
    step();
    expect_main("req_drop", 4'b0000, 2'd0, 1'b0);

    // ptr=2, requester 3 only -> grant 1000; held despite other done bits.
    request = 4'b1000;
    step();
    expect_main("own3", 4'b1000, 2'd3, 1'b1);
    done = 4'b0001;
    step();
    expect_main("own3_hold", 4'b1000, 2'd3, 1'b1);
    done = 4'b0000;

    // Asynchronous reset between edges drops the grant immediately.
    #2 reset = 1'b0;
    #1;
    expect_main("async_rst", 4'b0000, 2'd0, 1'b0);
    @(negedge clock);
    reset   = 1'b1;
    request = 4'b1010;  // ptr=0 selects 1; a stale ptr=2 would select 3
    step();
    expect_main("ptr_after_rst", 4'b0010, 2'd1, 1'b1);
    request = 4'b0000;
    step();

    // Hold limit: requester 1 keeps requesting, 2 waits.
    h_request = 4'b0110;
    step();
    expect_hold("pre_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      step();
      expect_hold($sformatf("pre_c%0d", k), 4'b0010, 2'd1, 1'b1, 1'b0);
    end
    step();
    expect_hold("preempt", 4'b0000, 2'd0, 1'b0, 1'b1);
    step();
    expect_hold("pre_next", 4'b0100, 2'd2, 1'b1, 1'b0);

    // Done coincident with the last allowed cycle is a normal release.
    for (int k = 2; k <= 4; k++) begin
      step();
      expect_hold($sformatf("co_c%0d", k), 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    h_done = 4'b0100;
    step();
    expect_hold("co_rel", 4'b0000, 2'd0, 1'b0, 1'b0);
    h_done = 4'b0000;
    step();
    // ptr=3 with requests 1,2 -> scan 3,0,1 -> 1 wins.
    expect_hold("co_next", 4'b0010, 2'd1, 1'b1, 1'b0);
    h_request = 4'b0000;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
